// File: rtl/serial_pkg.sv
// Shared types and frame geometry for the serial sum collector.
// SERIAL_COLLECT_PARITY_EN appends an even-parity bit to every frame.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic int frame_len(input int w);
`ifdef SERIAL_COLLECT_PARITY_EN
        return w + 1;
`else
        return w;
`endif
    endfunction

    localparam int FRAME_LEN = frame_len(DEFAULT_WIDTH);
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

endpackage

// File: rtl/shift_in_reg.sv
// Right-shifting serial-in/parallel-out register; new bits enter at the MSB.
// Latency: one edge per bit. No backpressure; clear with shift loads a lone MSB.
module shift_in_reg
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             shift_en_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = shift_en_i ? {bit_i, {(WIDTH-1){1'b0}}} : '0;
        end else if (shift_en_i) begin
            q_d = {bit_i, q_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/serial_sum_collector.sv
// Reassembles LSB-first sum frames into WIDTH-bit words with a valid/ready output buffer.
// Latency 1 cycle from last bit; a frame completing into a held, unaccepted word is dropped (overrun).
// SERIAL_COLLECT_PARITY_EN adds a trailing even-parity bit and the parity_err_o output.
module serial_sum_collector
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             bit_valid_i,
    input  logic             bit_in_i,
    input  logic             carry_in_i,
    output logic [WIDTH-1:0] word_out_o,
    output logic             carry_out_o,
`ifdef SERIAL_COLLECT_PARITY_EN
    output logic             parity_err_o,
`endif
    output logic             word_valid_o,
    input  logic             word_ready_i,
    output logic             busy_o,
    output logic             overrun_o,
    output logic             frame_err_o
);

    localparam int FLEN = frame_len(WIDTH);
    localparam int CW   = $clog2(FLEN + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             carry_q, carry_d;
    logic             perr_q, perr_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             ferr_q, ferr_d;

    logic             sr_clr, sr_shift;
    logic [WIDTH-1:0] sr_q;
    logic             frame_done, accept;
    logic [WIDTH-1:0] ld_word;
    logic             ld_perr;

    shift_in_reg #(.WIDTH(WIDTH)) u_shift (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (sr_clr),
        .shift_en_i (sr_shift),
        .bit_i      (bit_in_i),
        .q_o        (sr_q)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bit_valid_i) begin
            if (start_i) begin
                state_d = SHIFT;
            end else if (frame_done) begin
                state_d = IDLE;
            end
        end
    end

    // The last bit is used combinationally so the word loads on the same edge it arrives.
    always_comb begin
        busy_o     = (state_q == SHIFT);
        frame_done = busy_o && bit_valid_i && !start_i && (cnt_q == CW'(FLEN - 1));
        accept     = frame_done && (!valid_q || word_ready_i);
        overrun_d  = frame_done && !accept;
        ferr_d     = busy_o && bit_valid_i && start_i;
        sr_clr     = bit_valid_i && start_i;
`ifdef SERIAL_COLLECT_PARITY_EN
        sr_shift   = bit_valid_i && (start_i || (busy_o && (cnt_q < CW'(WIDTH))));
        ld_word    = sr_q;
        ld_perr    = bit_in_i ^ (^sr_q);
`else
        sr_shift   = bit_valid_i && (start_i || busy_o);
        ld_word    = {bit_in_i, {(WIDTH-1){1'b0}}} | (sr_q >> 1);
        ld_perr    = 1'b0;
`endif
    end

    always_comb begin
        cnt_d   = cnt_q;
        word_d  = word_q;
        carry_d = carry_q;
        perr_d  = perr_q;
        valid_d = valid_q;
        if (bit_valid_i && start_i) begin
            cnt_d = CW'(1);
        end else if (busy_o && bit_valid_i) begin
            cnt_d = frame_done ? '0 : cnt_q + CW'(1);
        end
        if (accept) begin
            word_d  = ld_word;
            carry_d = carry_in_i;
            perr_d  = ld_perr;
            valid_d = 1'b1;
        end else if (valid_q && word_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            word_q    <= '0;
            carry_q   <= 1'b0;
            perr_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            carry_q   <= carry_d;
            perr_q    <= perr_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
        end
    end

    assign word_out_o   = word_q;
    assign carry_out_o  = carry_q;
    assign word_valid_o = valid_q;
    assign overrun_o    = overrun_q;
    assign frame_err_o  = ferr_q;
`ifdef SERIAL_COLLECT_PARITY_EN
    assign parity_err_o = perr_q;
`else
    logic unused_perr;
    assign unused_perr = perr_q ^ ld_perr;
`endif

endmodule

// File: tb/tb_serial_sum_collector.sv
// Directed bench for serial_sum_collector with hand-computed frames.
// Covers the parity variant when SERIAL_COLLECT_PARITY_EN is defined.
module tb_serial_sum_collector;
    import serial_pkg::*;

    localparam int W  = 16;
    localparam int FL = frame_len(W);

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic          bit_valid_i = 1'b0;
    logic          bit_in_i = 1'b0;
    logic          carry_in_i = 1'b0;
    logic          word_ready_i = 1'b0;
    logic [W-1:0]  word_out_o;
    logic          carry_out_o;
    logic          word_valid_o;
    logic          busy_o;
    logic          overrun_o;
    logic          frame_err_o;
`ifdef SERIAL_COLLECT_PARITY_EN
    logic          parity_err_o;
`endif

    int checks = 0;
    int failures = 0;
    bit par_flip = 1'b0;

    serial_sum_collector #(.WIDTH(W)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .bit_valid_i  (bit_valid_i),
        .bit_in_i     (bit_in_i),
        .carry_in_i   (carry_in_i),
        .word_out_o   (word_out_o),
        .carry_out_o  (carry_out_o),
`ifdef SERIAL_COLLECT_PARITY_EN
        .parity_err_o (parity_err_o),
`endif
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .busy_o       (busy_o),
        .overrun_o    (overrun_o),
        .frame_err_o  (frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bit_valid_i = 1'b0;
        start_i     = 1'b0;
    endtask

    // Drives frame bits [first, first+n) starting at a negedge; returns at the negedge
    // after the last driven bit with inputs still asserted.
    task automatic send_bits(input logic [W-1:0] d, input logic c, input int first,
                             input int n, input bit gaps);
        logic [W-1:0] dv;
        dv = d;
        for (int i = first; i < first + n; i++) begin
            if (gaps && i > 0) begin
                int g;
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) begin
                    idle();
                    @(negedge clk_i);
                    check("busy_gap", {31'b0, busy_o}, 32'd1);
                end
                check("busy_mid", {31'b0, busy_o}, 32'd1);
            end
            bit_valid_i = 1'b1;
            start_i     = (i == 0);
            bit_in_i    = (i < W) ? dv[i] : ((^dv) ^ par_flip);
            carry_in_i  = (i == FL - 1) ? c : ~c;
            @(negedge clk_i);
        end
    endtask

    initial begin
        @(negedge clk_i);
        check("rst_word",  {16'b0, word_out_o}, 32'h0);
        check("rst_valid", {31'b0, word_valid_o}, 32'd0);
        check("rst_busy",  {31'b0, busy_o}, 32'd0);
        check("rst_ovr",   {31'b0, overrun_o}, 32'd0);
        check("rst_ferr",  {31'b0, frame_err_o}, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Frame 0x2143 carry 0, consecutive bits, one-cycle latency.
        word_ready_i = 1'b1;
        send_bits(16'h2143, 1'b0, 0, FL - 1, 1'b0);
        check("t1_prelast_valid", {31'b0, word_valid_o}, 32'd0);
        check("t1_prelast_busy",  {31'b0, busy_o}, 32'd1);
        send_bits(16'h2143, 1'b0, FL - 1, 1, 1'b0);
        idle();
        check("t1_valid", {31'b0, word_valid_o}, 32'd1);
        check("t1_word",  {16'b0, word_out_o}, 32'h2143);
        check("t1_carry", {31'b0, carry_out_o}, 32'd0);
        check("t1_busy",  {31'b0, busy_o}, 32'd0);
        @(negedge clk_i);
        check("t1_valid_drop", {31'b0, word_valid_o}, 32'd0);

        // Frame 0x0000 carry 1 with gaps; busy across the whole frame.
        send_bits(16'h0000, 1'b1, 0, FL, 1'b1);
        idle();
        check("t2_valid", {31'b0, word_valid_o}, 32'd1);
        check("t2_word",  {16'b0, word_out_o}, 32'h0000);
        check("t2_carry", {31'b0, carry_out_o}, 32'd1);
        check("t2_busy",  {31'b0, busy_o}, 32'd0);
        @(negedge clk_i);

        // Back-to-back 0xAAAA, 0x5555 with consumer stalled.
        word_ready_i = 1'b0;
        send_bits(16'hAAAA, 1'b0, 0, FL, 1'b0);
        check("t3_first_valid", {31'b0, word_valid_o}, 32'd1);
        check("t3_first_word",  {16'b0, word_out_o}, 32'hAAAA);
        check("t3_first_ovr",   {31'b0, overrun_o}, 32'd0);
        send_bits(16'h5555, 1'b1, 0, FL, 1'b0);
        idle();
        check("t3_ovr_pulse", {31'b0, overrun_o}, 32'd1);
        check("t3_hold_word", {16'b0, word_out_o}, 32'hAAAA);
        check("t3_hold_carry", {31'b0, carry_out_o}, 32'd0);
        @(negedge clk_i);
        check("t3_ovr_end",   {31'b0, overrun_o}, 32'd0);
        check("t3_hold_word2", {16'b0, word_out_o}, 32'hAAAA);
        word_ready_i = 1'b1;
        @(negedge clk_i);
        check("t3_valid_drop", {31'b0, word_valid_o}, 32'd0);
        @(negedge clk_i);
        check("t3_no_5555", {31'b0, word_valid_o}, 32'd0);

        // Early start at bit 7 of 0xFFFF, then full 0x0F0F.
        send_bits(16'hFFFF, 1'b0, 0, 7, 1'b0);
        send_bits(16'h0F0F, 1'b0, 0, 1, 1'b0);
        check("t4_ferr_pulse", {31'b0, frame_err_o}, 32'd1);
        check("t4_busy",       {31'b0, busy_o}, 32'd1);
        check("t4_no_valid",   {31'b0, word_valid_o}, 32'd0);
        send_bits(16'h0F0F, 1'b0, 1, FL - 1, 1'b0);
        idle();
        check("t4_ferr_end", {31'b0, frame_err_o}, 32'd0);
        check("t4_valid",    {31'b0, word_valid_o}, 32'd1);
        check("t4_word",     {16'b0, word_out_o}, 32'h0F0F);
        @(negedge clk_i);
        check("t4_one_word", {31'b0, word_valid_o}, 32'd0);

        // Reset at bit 9, then fresh 0x8001.
        send_bits(16'hFFFF, 1'b0, 0, 9, 1'b0);
        idle();
        rst_ni = 1'b0;
        #1;
        check("t5_rst_word",  {16'b0, word_out_o}, 32'h0);
        check("t5_rst_carry", {31'b0, carry_out_o}, 32'd0);
        check("t5_rst_valid", {31'b0, word_valid_o}, 32'd0);
        check("t5_rst_busy",  {31'b0, busy_o}, 32'd0);
        check("t5_rst_ferr",  {31'b0, frame_err_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        send_bits(16'h8001, 1'b0, 0, FL, 1'b0);
        idle();
        check("t5_valid", {31'b0, word_valid_o}, 32'd1);
        check("t5_word",  {16'b0, word_out_o}, 32'h8001);
        check("t5_ferr",  {31'b0, frame_err_o}, 32'd0);
        @(negedge clk_i);

`ifdef SERIAL_COLLECT_PARITY_EN
        // 0x0001 needs parity bit 1; send 0 first, then 1.
        par_flip = 1'b1;
        send_bits(16'h0001, 1'b0, 0, FL, 1'b0);
        idle();
        check("t6_word_bad", {16'b0, word_out_o}, 32'h0001);
        check("t6_perr_bad", {31'b0, parity_err_o}, 32'd1);
        @(negedge clk_i);
        par_flip = 1'b0;
        send_bits(16'h0001, 1'b0, 0, FL, 1'b0);
        idle();
        check("t6_word_ok", {16'b0, word_out_o}, 32'h0001);
        check("t6_perr_ok", {31'b0, parity_err_o}, 32'd0);
        @(negedge clk_i);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
